pstore_accum: RTL and testbench

- Parametrised successor to the partial-sum store in the neural-network datapath: NODES parallel lanes, each accumulating ACC_LEN signed weighted-input terms into an OUT_W-bit partial sum.
- Sits between the layer-1 multiply stage and the ReLU/activation stage.
- Adds a valid/ready handshake on input and output, a configurable batch length, early flush, saturating arithmetic with per-lane overflow flags, and a registered output that holds until consumed.

---
 rtl/pstore_accum_if.sv | 28 ++
 rtl/pstore_accum.sv | 115 +++++++++++
 tb/tb_pstore_accum.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pstore_accum_if.sv
// pstore_accum_if: valid/ready bus of the partial-sum store.
// master = producer/consumer side, slave = the accumulator block.
interface pstore_accum_if #(
  parameter int NODES = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int CNT_W = 4
);
  logic [NODES*IN_W-1:0]  weightsIn;
  logic                   in_valid;
  logic                   in_ready;
  logic                   flush;
  logic [NODES*OUT_W-1:0] sumOut;
  logic [NODES-1:0]       out_sat;
  logic                   out_valid;
  logic                   out_ready;
  logic [CNT_W-1:0]       beat_cnt;

  modport master (
    output weightsIn, in_valid, flush, out_ready,
    input  in_ready, sumOut, out_sat, out_valid, beat_cnt
  );

  modport slave (
    input  weightsIn, in_valid, flush, out_ready,
    output in_ready, sumOut, out_sat, out_valid, beat_cnt
  );
endinterface

// File: rtl/pstore_accum.sv
// pstore_accum: NODES-lane saturating partial-sum accumulator with
// valid/ready input and output, early flush and a held output register.
// Optional macro PSTORE_RELU_EN: apply ReLU to each lane as it is
// registered into sumOut (accumulators and out_sat see raw values).
module pstore_accum #(
  parameter int NODES   = 4,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 16,
  parameter int ACC_LEN = 16,
  parameter int CNT_W   = $clog2(ACC_LEN)
) (
  input  logic         clk,
  input  logic         clr,
  pstore_accum_if.slave bus
);

  localparam logic [CNT_W-1:0]       LAST    = CNT_W'(ACC_LEN - 1);
  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [NODES-1:0][OUT_W-1:0] r_acc;
  logic [NODES-1:0]            r_sticky;
  logic [CNT_W-1:0]            r_beat_cnt;
  logic [NODES-1:0][OUT_W-1:0] r_sum_out;
  logic [NODES-1:0]            r_out_sat;
  logic                        r_out_valid;

  logic                        w_slot_free;
  logic                        w_last;
  logic                        w_in_ready;
  logic                        w_beat;
  logic                        w_flush_ok;
  logic                        w_close;
  logic [NODES-1:0][OUT_W-1:0] w_acc_next;
  logic [NODES-1:0][OUT_W-1:0] w_sum_reg;
  logic [NODES-1:0]            w_ovf;

  // Only a batch-closing beat has to wait for the output slot.
  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_last      = (r_beat_cnt == LAST);
  assign w_in_ready  = w_slot_free || !w_last;
  assign w_beat      = bus.in_valid && w_in_ready;
  // An empty flush (no stored beats, no beat now) would emit a zero-length result, so it is ignored.
  assign w_flush_ok  = bus.flush && w_slot_free && ((r_beat_cnt != '0) || w_beat);
  assign w_close     = (w_beat && w_last) || w_flush_ok;

  // Per-lane next accumulator: first beat loads, later beats add, overflow clamps.
  always_comb begin
    logic signed [OUT_W:0] w_base;
    logic signed [OUT_W:0] w_term;
    logic signed [OUT_W:0] w_sum;
    // NOTE: every output of a combinational block gets a default up front so no path leaves it unassigned (which would infer a latch).
    w_ovf      = '0;
    w_acc_next = '0;
    w_sum_reg  = '0;
    for (int i = 0; i < NODES; i++) begin
      w_base = (r_beat_cnt == '0) ? '0 : {r_acc[i][OUT_W-1], r_acc[i]};
      w_term = w_beat ? {{(OUT_W+1-IN_W){bus.weightsIn[i*IN_W + IN_W - 1]}},
                         bus.weightsIn[i*IN_W +: IN_W]} : '0;
      w_sum  = w_base + w_term;
      // One guard bit is enough: |term| is far below the accumulator range.
      if (w_sum[OUT_W] != w_sum[OUT_W-1]) begin
        w_ovf[i]      = 1'b1;
        w_acc_next[i] = w_sum[OUT_W] ? SAT_MIN : SAT_MAX;
      end else begin
        w_acc_next[i] = w_sum[OUT_W-1:0];
      end
`ifdef PSTORE_RELU_EN
      w_sum_reg[i] = w_acc_next[i][OUT_W-1] ? '0 : w_acc_next[i];
`else
      w_sum_reg[i] = w_acc_next[i];
`endif
    end
  end

  // Accumulator, beat counter, sticky flags and the held output register.
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: the accumulator array is reset along with the control state, so a discarded partial batch leaves nothing behind.
      r_acc       <= '0;
      r_sticky    <= '0;
      r_beat_cnt  <= '0;
      r_sum_out   <= '0;
      r_out_sat   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_beat) begin
        r_acc <= w_acc_next;
      end
      if (w_close) begin
        r_beat_cnt  <= '0;
        r_sticky    <= '0;
        r_sum_out   <= w_sum_reg;
        r_out_sat   <= r_sticky | w_ovf;
        r_out_valid <= 1'b1;
      end else begin
        if (w_beat) begin
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          r_sticky   <= r_sticky | w_ovf;
        end
        if (bus.out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.sumOut    = r_sum_out;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_valid = r_out_valid;
  assign bus.beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_pstore_accum.sv
// tb_pstore_accum: two pstore_accum instances (OUT_W=16 and OUT_W=10) driven
// in lockstep; a reference model predicts results into a queue that a
// separate output monitor pops and compares.
module tb_pstore_accum;

  localparam int NODES   = 4;
  localparam int IN_W    = 8;
  localparam int ACC_LEN = 16;
  localparam int CNT_W   = $clog2(ACC_LEN);
  localparam int OW_A    = 16;
  localparam int OW_B    = 10;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic [NODES*IN_W-1:0] drv_w = '0;
  logic drv_v = 1'b0;
  logic drv_f = 1'b0;
  logic drv_r = 1'b1;

  pstore_accum_if #(.NODES(NODES), .IN_W(IN_W), .OUT_W(OW_A), .CNT_W(CNT_W)) bus_a ();
  pstore_accum_if #(.NODES(NODES), .IN_W(IN_W), .OUT_W(OW_B), .CNT_W(CNT_W)) bus_b ();

  assign bus_a.weightsIn = drv_w;
  assign bus_a.in_valid  = drv_v;
  assign bus_a.flush     = drv_f;
  assign bus_a.out_ready = drv_r;
  assign bus_b.weightsIn = drv_w;
  assign bus_b.in_valid  = drv_v;
  assign bus_b.flush     = drv_f;
  assign bus_b.out_ready = drv_r;

  pstore_accum #(.NODES(NODES), .IN_W(IN_W), .OUT_W(OW_A), .ACC_LEN(ACC_LEN), .CNT_W(CNT_W))
    u_dut_a (.clk(clk), .clr(clr), .bus(bus_a.slave));
  pstore_accum #(.NODES(NODES), .IN_W(IN_W), .OUT_W(OW_B), .ACC_LEN(ACC_LEN), .CNT_W(CNT_W))
    u_dut_b (.clk(clk), .clr(clr), .bus(bus_b.slave));

  typedef struct packed {
    logic [1:0][NODES-1:0][31:0] sum;
    logic [1:0][NODES-1:0]       sat;
  } res_t;

  res_t exp_q[$];
  int   m_acc [2][NODES];
  bit   m_sat [2][NODES];
  int   m_cnt     = 0;
  bit   m_pending = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int ow(input int k);
    return (k == 0) ? OW_A : OW_B;
  endfunction

  function automatic int relu(input int v);
`ifdef PSTORE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int lane_a(input int i);
    return int'($signed(bus_a.sumOut[i*OW_A +: OW_A]));
  endfunction

  function automatic int lane_b(input int i);
    return int'($signed(bus_b.sumOut[i*OW_B +: OW_B]));
  endfunction

  function automatic logic [NODES*IN_W-1:0] all_lanes(input int v);
    logic [NODES*IN_W-1:0] w;
    for (int i = 0; i < NODES; i++) w[i*IN_W +: IN_W] = IN_W'(v);
    return w;
  endfunction

  // Reference model: one rising edge worth of the block's rules, using the
  // inputs held across that edge.
  task automatic model_edge();
    bit   slot, beat, fl;
    int   t, s, hi, lo;
    res_t r;
    if (clr) begin
      m_cnt = 0;
      m_pending = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NODES; i++) begin
          m_acc[k][i] = 0;
          m_sat[k][i] = 1'b0;
        end
      exp_q.delete();
      return;
    end
    slot = !m_pending || drv_r;
    beat = drv_v && (slot || (m_cnt != ACC_LEN - 1));
    fl   = drv_f && slot && ((m_cnt > 0) || beat);
    if (beat) begin
      for (int k = 0; k < 2; k++) begin
        hi = (1 << (ow(k) - 1)) - 1;
        lo = -(1 << (ow(k) - 1));
        for (int i = 0; i < NODES; i++) begin
          t = $signed(drv_w[i*IN_W +: IN_W]);
          s = m_acc[k][i] + t;
          if (s > hi) begin s = hi; m_sat[k][i] = 1'b1; end
          if (s < lo) begin s = lo; m_sat[k][i] = 1'b1; end
          m_acc[k][i] = s;
        end
      end
      m_cnt++;
    end
    if ((m_cnt == ACC_LEN) || fl) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NODES; i++) begin
          r.sum[k][i] = 32'(relu(m_acc[k][i]));
          r.sat[k][i] = m_sat[k][i];
          m_acc[k][i] = 0;
          m_sat[k][i] = 1'b0;
        end
      exp_q.push_back(r);
      m_cnt = 0;
      m_pending = 1'b1;
    end else if (drv_r) begin
      m_pending = 1'b0;
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check state.
  task automatic step(input logic v, input logic [NODES*IN_W-1:0] w,
                      input logic f, input logic r, input logic c);
    bit exp_rdy;
    drv_v = v; drv_w = w; drv_f = f; drv_r = r; clr = c;
    #1;
    if (!c) begin
      exp_rdy = !m_pending || r || (m_cnt != ACC_LEN - 1);
      check("in_ready_a", bus_a.in_ready, exp_rdy);
      check("in_ready_b", bus_b.in_ready, exp_rdy);
    end
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid_a", bus_a.out_valid, m_pending);
    check("out_valid_b", bus_b.out_valid, m_pending);
    check("beat_cnt_a", bus_a.beat_cnt, m_cnt);
    check("beat_cnt_b", bus_b.beat_cnt, m_cnt);
  endtask

  // Output monitor: compares each consumed result and checks hold stability.
  logic [NODES*OW_A-1:0] prev_sum_a;
  logic [NODES-1:0]      prev_sat_a;
  bit                    prev_hold = 1'b0;

  always @(negedge clk) begin
    res_t e;
    if (!clr && prev_hold && bus_a.out_valid) begin
      check("hold_sum_a", bus_a.sumOut, prev_sum_a);
      check("hold_sat_a", bus_a.out_sat, prev_sat_a);
    end
    prev_hold  = !clr && bus_a.out_valid && !drv_r;
    prev_sum_a = bus_a.sumOut;
    prev_sat_a = bus_a.out_sat;
    if (!clr && bus_a.out_valid && drv_r) begin
      check("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NODES; i++) begin
          check($sformatf("sum_a[%0d]", i), lane_a(i), int'($signed(e.sum[0][i])));
          check($sformatf("sum_b[%0d]", i), lane_b(i), int'($signed(e.sum[1][i])));
        end
        check("sat_a", bus_a.out_sat, e.sat[0]);
        check("sat_b", bus_b.out_sat, e.sat[1]);
      end
    end
  end

  initial begin
    logic [NODES*IN_W-1:0] w;

    // Reset
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_sumOut", bus_a.sumOut, 0);
    check("rst_out_sat", bus_a.out_sat, 0);

    // Basic: 16 beats of +1 on every lane
    for (int n = 0; n < ACC_LEN; n++) step(1'b1, all_lanes(1), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NODES; i++) check("basic_lane", lane_a(i), 16);
    check("basic_sat", bus_a.out_sat, 0);
    check("basic_cnt", bus_a.beat_cnt, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Mixed signs: lane0 +127, lane1 -128
    w = '0; w[7:0] = 8'h7F; w[15:8] = 8'h80;
    for (int n = 0; n < ACC_LEN; n++) step(1'b1, w, 1'b0, 1'b1, 1'b0);
    check("mixed_lane0", lane_a(0), relu(2032));
    check("mixed_lane1", lane_a(1), relu(-2048));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Saturation on the OUT_W=10 instance: lane0 +127, others +1
    w = all_lanes(1); w[7:0] = 8'h7F;
    for (int n = 0; n < ACC_LEN; n++) step(1'b1, w, 1'b0, 1'b1, 1'b0);
    check("sat_lane0_b", lane_b(0), 511);
    check("sat_flags_b", bus_b.out_sat, 4'b0001);
    check("sat_flags_a", bus_a.out_sat, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Reload after a batch: -1 x16 leaves no residue, sticky flag cleared
    for (int n = 0; n < ACC_LEN; n++) step(1'b1, all_lanes(-1), 1'b0, 1'b1, 1'b0);
    check("reload_lane0", lane_a(0), relu(-16));
    check("reload_sat_b", bus_b.out_sat, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Backpressure: batch 1 held, 16th beat of batch 2 stalls
    for (int n = 0; n < ACC_LEN; n++) step(1'b1, all_lanes(2), 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < ACC_LEN - 1; n++) step(1'b1, all_lanes(1), 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b1, all_lanes(1), 1'b0, 1'b0, 1'b0);
    check("bp_in_ready", bus_a.in_ready, 0);
    check("bp_held", lane_a(0), 32);
    step(1'b1, all_lanes(1), 1'b0, 1'b1, 1'b0);
    check("bp_batch2", lane_a(0), 16);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Flush: 5 beats of +3 then flush with a 6th beat
    for (int n = 0; n < 5; n++) step(1'b1, all_lanes(3), 1'b0, 1'b1, 1'b0);
    step(1'b1, all_lanes(3), 1'b1, 1'b1, 1'b0);
    check("flush_lane0", lane_a(0), 18);
    check("flush_cnt", bus_a.beat_cnt, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("flush_empty", bus_a.out_valid, 0);

    // Reset mid-batch with an unconsumed result
    for (int n = 0; n < ACC_LEN; n++) step(1'b1, all_lanes(1), 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 7; n++) step(1'b1, all_lanes(1), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("midrst_valid", bus_a.out_valid, 0);
    check("midrst_sum", bus_a.sumOut, 0);
    check("midrst_cnt", bus_a.beat_cnt, 0);
    for (int n = 0; n < ACC_LEN; n++) step(1'b1, all_lanes(2), 1'b0, 1'b1, 1'b0);
    check("midrst_after", lane_a(0), 32);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom % 4) != 0, NODES*IN_W'($urandom), ($urandom % 12) == 0,
           ($urandom % 4) != 0, ($urandom % 600) == 0);
    end

    // Drain
    for (int n = 0; n < 4; n++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
